shift_divider: RTL and testbench
================================

// Module: shift_divider
// PURPOSE
//  Sequential restoring shift-subtract divider: unsigned N-bit dividend / N-bit divisor -> quotient, remainder.
//  Inverse companion of the shift-add multiplier datapath; one quotient bit per clock over an A:Q shift register.
//  Self-contained FSM + datapath; driven by a start/busy/done handshake from the arithmetic controller.
// PARAMETERS
//  N    4   operand width in bits (dividend, divisor, quotient, remainder); N >= 2
// PORTS
//  clock      in   1  rising-edge clock
//  reset      in   1  synchronous, active-high reset
//  start      in   1  request a division; sampled only in IDLE
//  dividend   in   N  dividend, captured on accepted start
//  divisor    in   N  divisor, captured on accepted start
//  busy       out  1  high while an operation is in progress (RUN)
//  done       out  1  one-cycle pulse: quotient/remainder valid from this cycle
//  quotient   out  N  result quotient; held until the next accepted start
//  remainder  out  N  result remainder; held until the next accepted start
//  div_zero   out  1  divisor was zero (DIV_ZERO_DETECT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (clock, reset synchronous active-high): state=IDLE; busy=0, done=0, div_zero=0, quotient=0, remainder=0.
//  Reset mid-operation aborts immediately; no done pulse; results cleared to 0.
//  Regs: A (N+1 bits, partial remainder), Q (N bits), M (N bits, divisor), cnt (clog2(N+1) bits).
//  States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 -> A=0, Q=dividend, M=divisor, cnt=N, go RUN. start=0 -> stay. done=0.
//   RUN (busy=1): per cycle: {A,Q} <<= 1; T = A - {1'b0,M};
//     T >= 0 (MSB 0): A=T, Q[0]=1;  else A unchanged (restored), Q[0]=0.  cnt--.
//     After the cycle with cnt==1 -> DONE. Exactly N RUN cycles.
//   DONE: quotient=Q, remainder=A[N-1:0] registered; done=1 for this one cycle; busy=0; -> IDLE.
//  Latency: start accepted at edge k -> busy high edges k+1..k+N -> done high in cycle after edge k+N+1.
//  start while busy or in DONE is ignored (no queuing); start may be held high -> back-to-back ops, 1 IDLE cycle between.
//  Results stable from done until the edge that accepts the next start; outputs unchanged during RUN.
//  Operands sampled only at accept; changing dividend/divisor during RUN has no effect.
//  Width rule: trial subtract in N+1 bits; remainder < divisor always when divisor != 0.
// CONFIGURATION
//  `define DIV_ZERO_DETECT_EN:
//   with: divisor==0 at accept -> IDLE goes straight to DONE (skips RUN), quotient={N{1}},
//         remainder=dividend, div_zero=1 held with results; any nonzero divide clears div_zero at its done.
//   without: no detection; divisor 0 runs the full N cycles and yields quotient={N{1}},
//         remainder=dividend by the algorithm; div_zero constant 0.
// STRUCTURE
//  Package shift_div_pkg: typedef enum logic[1:0] {IDLE, RUN, DONE} div_state_t;
//   function cnt_width(N) = $clog2(N+1).
//  Sub-module shift_div_register: holds A/Q/M, performs the load, shift-and-trial-subtract step and
//   restore under load/step controls from the FSM; FSM, counter and output registers stay in shift_divider.
// TESTING (N=4 unless noted)
//  T1: reset, start with 13/4 -> busy 4 cycles, done pulse, quotient=3, remainder=1, div_zero=0.
//  T2: 15/1 -> quotient=15, remainder=0;  3/7 -> quotient=0, remainder=3;  0/5 -> 0, 0.
//  T3: 9/0 -> macro on: done 1 cycle after accept, no busy, div_zero=1, quotient=15, remainder=9;
//      macro off: 4 busy cycles, quotient=15, remainder=9, div_zero=0.
//  T4: start 12/5, assert start with 7/2 during RUN -> ignored; results 2/2; then start 7/2 -> 3/1.
//  T5: reset asserted at 2nd RUN cycle of 14/3 -> next cycle busy=0, done never, outputs 0; new 14/3 -> 4/2.
//  T6: N=8 exhaustive random 1000 pairs vs reference model a/b, a%b; check done latency = N+1 each.

Source files
------------

// File: rtl/shift_div_pkg.sv
// Shared types and helpers for the sequential restoring shift-subtract divider.
package shift_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    // Counter must hold the value N itself, hence N+1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_divider_if.sv
// Start/busy/done handshake and operand/result bus of the shift divider.
interface shift_divider_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/shift_div_register.sv
// A:Q shift register with divisor M; one restoring shift-and-trial-subtract step per cycle.
module shift_div_register #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quo,
    output logic [N-1:0] rem
);
    logic [N:0]   a;
    logic [N-1:0] q;
    logic [N-1:0] m;
    logic [N+1:0] trial;

    // Shift {A,Q} left by one, then subtract M; the top bit is the borrow.
    assign trial = {a, q[N-1]} - {2'b00, m};

    always_ff @(posedge clock) begin
        if (reset) begin
            a <= '0;
            q <= '0;
            m <= '0;
        end else if (load) begin
            a <= '0;
            q <= dividend;
            m <= divisor;
        end else if (step) begin
            if (!trial[N+1]) begin
                a <= trial[N:0];
                q <= {q[N-2:0], 1'b1};
            end else begin
                a <= {a[N-1:0], q[N-1]};
                q <= {q[N-2:0], 1'b0};
            end
        end
    end

    assign quo = q;
    assign rem = a[N-1:0];
endmodule

// File: rtl/shift_divider.sv
// Sequential restoring divider: FSM, step counter and result registers.
// Optional DIV_ZERO_DETECT_EN: zero divisor skips RUN and flags div_zero.
module shift_divider
    import shift_div_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input logic            clock,
    input logic            reset,
    shift_divider_if.slave bus
);
    localparam int unsigned CW = cnt_width(N);

    div_state_t   state;
    logic [CW-1:0] cnt;
    logic         busy_reg;
    logic         done_reg;
    logic [N-1:0] quotient_reg;
    logic [N-1:0] remainder_reg;
    logic         load;
    logic         step;
    logic [N-1:0] quo;
    logic [N-1:0] rem;

    assign load = (state == IDLE) && bus.start;
    assign step = (state == RUN);

    shift_div_register #(.N(N)) u_reg (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .dividend (bus.dividend),
        .divisor  (bus.divisor),
        .quo      (quo),
        .rem      (rem)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic dz;
    logic div_zero_reg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz            <= 1'b0;
            div_zero_reg  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        cnt <= CW'(N);
`ifdef DIV_ZERO_DETECT_EN
                        dz <= (bus.divisor == '0);
                        if (bus.divisor == '0) begin
                            state <= DONE;
                        end else begin
                            busy_reg <= 1'b1;
                            state    <= RUN;
                        end
`else
                        busy_reg <= 1'b1;
                        state    <= RUN;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy_reg <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                    // Q was loaded with the dividend and never stepped on the zero path.
                    quotient_reg  <= dz ? '1 : quo;
                    remainder_reg <= dz ? quo : rem;
                    div_zero_reg  <= dz;
`else
                    quotient_reg  <= quo;
                    remainder_reg <= rem;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero  = div_zero_reg;
`else
    assign bus.div_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_shift_divider.sv
// Self-checking bench: directed N=4 cases with literal results plus N=8 random ops vs a/b, a%b.
module tb_shift_divider;
    import shift_div_pkg::*;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DzEn = 1'b1;
`else
    localparam bit DzEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    shift_divider_if #(.N(4)) if4 ();
    shift_divider_if #(.N(8)) if8 ();

    shift_divider #(.N(4)) dut4 (.clock(clock), .reset(reset), .bus(if4.slave));
    shift_divider #(.N(8)) dut8 (.clock(clock), .reset(reset), .bus(if8.slave));

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Last result each instance must be holding (index 0: N=4, 1: N=8).
    logic [7:0] last_q  [2];
    logic [7:0] last_r  [2];
    logic       last_dz [2];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit w8, input logic st, input logic [7:0] a, input logic [7:0] d);
        if (w8) begin
            if8.start = st; if8.dividend = a; if8.divisor = d;
        end else begin
            if4.start = st; if4.dividend = a[3:0]; if4.divisor = d[3:0];
        end
    endtask

    task automatic sample(input bit w8, output logic b, output logic dn,
                          output logic [7:0] q, output logic [7:0] r, output logic z);
        if (w8) begin
            b = if8.busy; dn = if8.done; q = if8.quotient; r = if8.remainder; z = if8.div_zero;
        end else begin
            b = if4.busy; dn = if4.done; q = {4'h0, if4.quotient};
            r = {4'h0, if4.remainder}; z = if4.div_zero;
        end
    endtask

    // Idle cycle before a new request: done must have fallen, results still held.
    task automatic launch(input bit w8, input logic [7:0] a, input logic [7:0] d);
        logic b, dn, z;
        logic [7:0] q, r;
        @(negedge clock);
        sample(w8, b, dn, q, r, z);
        chk("idle busy", b, 0);
        chk("idle done", dn, 0);
        chk("idle quotient held", q, last_q[w8]);
        drive(w8, 1'b1, a, d);
    endtask

    // Check every cycle of one accepted operation until its done pulse.
    task automatic follow(input bit w8, input string tag, input logic [7:0] eq,
                          input logic [7:0] er, input logic edz, input bit zero_path,
                          input bit inject);
        int unsigned nb;
        int unsigned lat;
        logic b, dn, z;
        logic [7:0] q, r;
        nb  = zero_path ? 0 : (w8 ? 8 : 4);
        lat = nb + 2;
        for (int unsigned i = 1; i <= lat; i++) begin
            @(negedge clock);
            if (i == 1) drive(w8, 1'b0, 8'($urandom), 8'($urandom));
            if (inject && i == 2) drive(w8, 1'b1, 8'd7, 8'd2);
            sample(w8, b, dn, q, r, z);
            chk($sformatf("%s busy c%0d", tag, i), b, (i <= nb) ? 1 : 0);
            chk($sformatf("%s done c%0d", tag, i), dn, (i == lat) ? 1 : 0);
            if (i < lat) begin
                chk($sformatf("%s held q c%0d", tag, i), q, last_q[w8]);
                chk($sformatf("%s held r c%0d", tag, i), r, last_r[w8]);
                chk($sformatf("%s held dz c%0d", tag, i), z, last_dz[w8]);
            end else begin
                chk($sformatf("%s quotient", tag), q, eq);
                chk($sformatf("%s remainder", tag), r, er);
                chk($sformatf("%s div_zero", tag), z, edz);
                last_q[w8]  = eq;
                last_r[w8]  = er;
                last_dz[w8] = edz;
            end
        end
    endtask

    task automatic check_cleared(input bit w8, input string tag);
        logic b, dn, z;
        logic [7:0] q, r;
        sample(w8, b, dn, q, r, z);
        chk({tag, " busy"}, b, 0);
        chk({tag, " done"}, dn, 0);
        chk({tag, " quotient"}, q, 0);
        chk({tag, " remainder"}, r, 0);
        chk({tag, " div_zero"}, z, 0);
    endtask

    initial begin
        logic [7:0] a, d, eq, er;
        bit zp;
        for (int k = 0; k < 2; k++) begin
            last_q[k] = '0; last_r[k] = '0; last_dz[k] = 1'b0;
        end
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        repeat (3) @(negedge clock);
        check_cleared(1'b0, "reset n4");
        check_cleared(1'b1, "reset n8");
        reset = 1'b0;

        // T1/T2: basic divides, literal results.
        launch(1'b0, 8'd13, 8'd4); follow(1'b0, "13/4", 8'd3, 8'd1, 1'b0, 1'b0, 1'b0);
        launch(1'b0, 8'd15, 8'd1); follow(1'b0, "15/1", 8'd15, 8'd0, 1'b0, 1'b0, 1'b0);
        launch(1'b0, 8'd3, 8'd7);  follow(1'b0, "3/7", 8'd0, 8'd3, 1'b0, 1'b0, 1'b0);
        launch(1'b0, 8'd0, 8'd5);  follow(1'b0, "0/5", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // T3: zero divisor, then a nonzero divide clears the flag.
        launch(1'b0, 8'd9, 8'd0);  follow(1'b0, "9/0", 8'd15, 8'd9, DzEn, DzEn, 1'b0);
        launch(1'b0, 8'd10, 8'd3); follow(1'b0, "10/3", 8'd3, 8'd1, 1'b0, 1'b0, 1'b0);

        // T4: start during RUN ignored; held start gives a back-to-back op.
        launch(1'b0, 8'd12, 8'd5); follow(1'b0, "12/5", 8'd2, 8'd2, 1'b0, 1'b0, 1'b1);
        follow(1'b0, "7/2 b2b", 8'd3, 8'd1, 1'b0, 1'b0, 1'b0);

        // T5: reset at the 2nd RUN cycle aborts and clears.
        launch(1'b0, 8'd14, 8'd3);
        @(negedge clock);
        drive(1'b0, 1'b0, 8'd14, 8'd3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_cleared(1'b0, "abort");
        for (int k = 0; k < 2; k++) begin
            last_q[k] = '0; last_r[k] = '0; last_dz[k] = 1'b0;
        end
        repeat (3) begin
            @(negedge clock);
            chk("abort no done", if4.done, 0);
        end
        launch(1'b0, 8'd14, 8'd3); follow(1'b0, "14/3", 8'd4, 8'd2, 1'b0, 1'b0, 1'b0);

        // T6: N=8 random operands against plain arithmetic.
        for (int t = 0; t < 1000; t++) begin
            a  = 8'($urandom_range(0, 255));
            d  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            eq = (d == 0) ? 8'hff : a / d;
            er = (d == 0) ? a : a % d;
            zp = DzEn && (d == 0);
            launch(1'b1, a, d);
            follow(1'b1, $sformatf("rnd %0d/%0d", a, d), eq, er, zp, zp, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
